// File: rtl/sdram_timing_checker.sv
// Passive SDRAM command-bus monitor: tracks bank state and command spacing and
// latches the first timing/protocol violation, counting every violating cycle.
module sdram_timing_checker #(
    parameter int          BANKS       = 4,
    parameter int          A_W         = 13,
    parameter int          T_RCD       = 2,
    parameter int          T_RAS       = 5,
    parameter int          T_RC        = 7,
    parameter int          T_RP        = 2,
    parameter int          T_RRD       = 2,
    parameter int          T_RFC       = 7,
    parameter int          REF_ROWS    = 8192,
    parameter int          T_REFW      = 6400000,
    parameter int unsigned MODE_EXPECT = 15'h0020
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cke_n,
    input  logic                       cs_n,
    input  logic                       ras_n,
    input  logic                       cas_n,
    input  logic                       we_n,
    input  logic [$clog2(BANKS)-1:0]   ba,
    input  logic [A_W-1:0]             a,
    output logic [BANKS-1:0]           open_banks,
    output logic                       err,
    output logic [3:0]                 err_code,
    output logic [$clog2(BANKS)-1:0]   err_bank,
    output logic [15:0]                err_count
);

    localparam int BA_W = $clog2(BANKS);
    localparam int CW   = 8;
    localparam int RW_W = $clog2(T_REFW + 1);
    localparam int RC_W = $clog2(REF_ROWS + 1);
    localparam logic [CW-1:0]        CMAX  = '1;
    localparam logic [CW-1:0]        TRCD  = CW'(T_RCD);
    localparam logic [CW-1:0]        TRAS  = CW'(T_RAS);
    localparam logic [CW-1:0]        TRC   = CW'(T_RC);
    localparam logic [CW-1:0]        TRP   = CW'(T_RP);
    localparam logic [CW-1:0]        TRRD  = CW'(T_RRD);
    localparam logic [CW-1:0]        TRFC  = CW'(T_RFC);
    localparam logic [RW_W-1:0]      TREFW = RW_W'(T_REFW);
    localparam logic [RC_W-1:0]      RLAST = RC_W'(REF_ROWS - 1);
    localparam logic [BA_W+A_W-1:0]  MODE_V = (BA_W + A_W)'(MODE_EXPECT);

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS
    } cmd_t;

    cmd_t             cmd;
    logic [CW-1:0]    act_cnt [BANKS];
    logic [CW-1:0]    pre_cnt [BANKS];
    logic [CW-1:0]    act_any_cnt;
    logic [CW-1:0]    ref_dist;
    logic [RW_W-1:0]  refw_cnt;
    logic             refw_hit;
    logic [RC_W-1:0]  ref_rows_cnt;
    logic [15:0]      v;
    logic [BANKS-1:0] ras_early;
    logic             rp_early_any;
    logic [BA_W-1:0]  ras_bank;
    logic [3:0]       viol_code;
    logic [BA_W-1:0]  viol_bank;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CMAX) ? c : c + 8'd1;
    endfunction

    always_comb begin
        cmd = CMD_NOP;
        if (!cke_n && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // All rule checks run in parallel; the lowest set code wins.
    always_comb begin
        ras_early    = '0;
        rp_early_any = 1'b0;
        ras_bank     = '0;
        for (int b = 0; b < BANKS; b++) begin
            ras_early[b] = open_banks[b] && (act_cnt[b] < TRAS);
            if (pre_cnt[b] < TRP) rp_early_any = 1'b1;
        end
        for (int b = BANKS - 1; b >= 0; b--) begin
            if (ras_early[b]) ras_bank = BA_W'(b);
        end

        v     = '0;
        v[1]  = (cmd == CMD_ACT) && open_banks[ba];
        v[2]  = ((cmd == CMD_RD) || (cmd == CMD_WR)) && !open_banks[ba];
        v[3]  = ((cmd == CMD_RD) || (cmd == CMD_WR)) && (act_cnt[ba] < TRCD);
        v[4]  = (cmd == CMD_PRE) && (a[10] ? |ras_early : ras_early[ba]);
        v[5]  = (cmd == CMD_ACT) && (act_cnt[ba] < TRC);
        v[6]  = ((cmd == CMD_ACT) && (pre_cnt[ba] < TRP)) ||
                ((cmd == CMD_REF) && rp_early_any);
        v[7]  = (cmd == CMD_ACT) && (act_any_cnt < TRRD);
        v[8]  = (cmd != CMD_NOP) && (ref_dist < TRFC);
        v[9]  = (cmd == CMD_REF) && |open_banks;
        v[10] = (cmd == CMD_MRS) && (({ba, a} != MODE_V) || |open_banks);
        v[11] = (refw_cnt == TREFW) && !refw_hit;

        viol_code = 4'd0;
        for (int i = 11; i >= 1; i--) begin
            if (v[i]) viol_code = 4'(i);
        end

        viol_bank = '0;
        case (viol_code)
            4'd1, 4'd2, 4'd3, 4'd5, 4'd7: viol_bank = ba;
            4'd4:    viol_bank = a[10] ? ras_bank : ba;
            4'd6:    viol_bank = (cmd == CMD_ACT) ? ba : '0;
            default: viol_bank = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_banks   <= '0;
            err          <= 1'b0;
            err_code     <= 4'd0;
            err_bank     <= '0;
            err_count    <= 16'd0;
            act_any_cnt  <= CMAX;
            ref_dist     <= CMAX;
            refw_cnt     <= '0;
            refw_hit     <= 1'b0;
            ref_rows_cnt <= '0;
            for (int b = 0; b < BANKS; b++) begin
                act_cnt[b] <= CMAX;
                pre_cnt[b] <= CMAX;
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                act_cnt[b] <= sat_inc(act_cnt[b]);
                pre_cnt[b] <= sat_inc(pre_cnt[b]);
            end
            act_any_cnt <= sat_inc(act_any_cnt);
            ref_dist    <= sat_inc(ref_dist);
            if (refw_cnt != TREFW) refw_cnt <= refw_cnt + 1'b1;
            if (v[11]) refw_hit <= 1'b1;

            case (cmd)
                CMD_ACT: begin
                    open_banks[ba] <= 1'b1;
                    act_cnt[ba]    <= 8'd1;
                    act_any_cnt    <= 8'd1;
                end
                CMD_PRE: begin
                    // Precharging an idle bank leaves its PRE timestamp untouched.
                    for (int b = 0; b < BANKS; b++) begin
                        if ((a[10] || (ba == BA_W'(b))) && open_banks[b]) begin
                            open_banks[b] <= 1'b0;
                            pre_cnt[b]    <= 8'd1;
                        end
                    end
                end
                CMD_REF: begin
                    ref_dist     <= 8'd1;
                    ref_rows_cnt <= (ref_rows_cnt == RLAST) ? '0 : ref_rows_cnt + 1'b1;
                    if (ref_rows_cnt == '0) begin
                        refw_cnt <= '0;
                        refw_hit <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (viol_code != 4'd0) begin
                if (!err) begin
                    err      <= 1'b1;
                    err_code <= viol_code;
                    err_bank <= viol_bank;
                end
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_timing_checker.sv
// Randomized and directed bench for sdram_timing_checker against a cycle-stamp
// reference model (absolute cycle numbers, no saturating counters).
module tb_sdram_timing_checker;

    localparam int BANKS    = 4;
    localparam int A_W      = 13;
    localparam int T_RCD    = 2;
    localparam int T_RAS    = 5;
    localparam int T_RC     = 7;
    localparam int T_RP     = 2;
    localparam int T_RRD    = 2;
    localparam int T_RFC    = 7;
    localparam int REF_ROWS = 2;
    localparam int T_REFW   = 100;
    localparam int MODE     = 15'h0020;
    localparam int NEVER    = -1000000;

    localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4,
                   C_REF = 5, C_MRS = 6, C_DESEL = 7, C_CKE = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cke_n, cs_n, ras_n, cas_n, we_n;
    logic [1:0]       ba;
    logic [A_W-1:0]   a;
    logic [BANKS-1:0] open_banks;
    logic             err;
    logic [3:0]       err_code;
    logic [1:0]       err_bank;
    logic [15:0]      err_count;

    sdram_timing_checker #(
        .BANKS(BANKS), .A_W(A_W), .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RC(T_RC),
        .T_RP(T_RP), .T_RRD(T_RRD), .T_RFC(T_RFC), .REF_ROWS(REF_ROWS),
        .T_REFW(T_REFW), .MODE_EXPECT(MODE)
    ) dut (
        .clk(clk), .rst(rst), .cke_n(cke_n), .cs_n(cs_n), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .ba(ba), .a(a), .open_banks(open_banks),
        .err(err), .err_code(err_code), .err_bank(err_bank), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model state, all timestamps are absolute cycle numbers
    int cyc;
    bit m_open [BANKS];
    int last_act [BANKS];
    int last_pre [BANKS];
    int last_act_any, last_ref, win_start, ref_mod;
    bit win_fired;
    bit m_err;
    int m_code, m_bank, m_count;
    int best_code, best_bank;

    function automatic int open_mask();
        int m = 0;
        for (int b = 0; b < BANKS; b++) if (m_open[b]) m |= (1 << b);
        return m;
    endfunction

    function automatic void note(input int c, input int b);
        if (c < best_code) begin
            best_code = c;
            best_bank = b;
        end
    endfunction

    task automatic model_reset(input int n);
        for (int b = 0; b < BANKS; b++) begin
            m_open[b]   = 0;
            last_act[b] = NEVER;
            last_pre[b] = NEVER;
        end
        last_act_any = NEVER;
        last_ref     = NEVER;
        win_start    = n + 1;
        win_fired    = 0;
        ref_mod      = 0;
        m_err = 0; m_code = 0; m_bank = 0; m_count = 0;
    endtask

    task automatic model_cycle(input bit r, input int c, input int b, input int addr);
        int n = cyc;
        bit any_open = (open_mask() != 0);
        if (r) begin
            model_reset(n);
            return;
        end
        best_code = 99;
        best_bank = 0;
        case (c)
            C_ACT: begin
                if (m_open[b]) note(1, b);
                if (n - last_act[b] < T_RC) note(5, b);
                if (n - last_pre[b] < T_RP) note(6, b);
                if (n - last_act_any < T_RRD) note(7, b);
            end
            C_RD, C_WR: begin
                if (!m_open[b]) note(2, b);
                if (n - last_act[b] < T_RCD) note(3, b);
            end
            C_PRE: begin
                for (int t = 0; t < BANKS; t++)
                    if ((addr[10] || t == b) && m_open[t] && (n - last_act[t] < T_RAS))
                        note(4, t);
            end
            C_REF: begin
                for (int t = 0; t < BANKS; t++)
                    if (n - last_pre[t] < T_RP) note(6, 0);
                if (any_open) note(9, 0);
            end
            C_MRS: begin
                if ((((b << A_W) | addr) != MODE) || any_open) note(10, 0);
            end
            default: ;
        endcase
        if (c >= C_ACT && c <= C_MRS && (n - last_ref < T_RFC)) note(8, 0);
        if (!win_fired && (n - win_start == T_REFW)) begin
            note(11, 0);
            win_fired = 1;
        end
        case (c)
            C_ACT: begin
                m_open[b] = 1;
                last_act[b] = n;
                last_act_any = n;
            end
            C_PRE: begin
                for (int t = 0; t < BANKS; t++)
                    if ((addr[10] || t == b) && m_open[t]) begin
                        m_open[t] = 0;
                        last_pre[t] = n;
                    end
            end
            C_REF: begin
                last_ref = n;
                if (ref_mod == 0) begin
                    win_start = n + 1;
                    win_fired = 0;
                end
                ref_mod = (ref_mod + 1) % REF_ROWS;
            end
            default: ;
        endcase
        if (best_code != 99) begin
            if (!m_err) begin
                m_err = 1;
                m_code = best_code;
                m_bank = best_bank;
            end
            if (m_count < 16'hFFFF) m_count++;
        end
    endtask

    task automatic step(input bit r, input int c, input int b, input int addr);
        logic [2:0] rcw;
        @(negedge clk);
        rst   = r;
        cke_n = 1'b0;
        cs_n  = 1'b0;
        ba    = 2'(b);
        a     = A_W'(addr);
        case (c)
            C_ACT:   rcw = 3'b011;
            C_RD:    rcw = 3'b101;
            C_WR:    rcw = 3'b100;
            C_PRE:   rcw = 3'b010;
            C_REF:   rcw = 3'b001;
            C_MRS:   rcw = 3'b000;
            C_DESEL: begin rcw = 3'($urandom); cs_n = 1'b1; end
            C_CKE:   begin rcw = 3'($urandom); cke_n = 1'b1; cs_n = 1'($urandom); end
            default: rcw = 3'b110 | 3'($urandom_range(0, 1));
        endcase
        {ras_n, cas_n, we_n} = rcw;
        @(posedge clk);
        model_cycle(r, c, b, addr);
        cyc++;
        #1;
        chk("open_banks", open_banks, open_mask());
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        chk("err_bank", err_bank, m_bank);
        chk("err_count", err_count, m_count);
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) step(0, C_NOP, 0, 0);
    endtask

    task automatic do_reset();
        step(1, C_NOP, 0, 0);
        step(1, C_ACT, $urandom_range(0, 3), 0);
    endtask

    initial begin
        int c, b, addr, roll;
        cyc = 0;
        model_reset(0);
        rst = 1'b1; cke_n = 1'b1; cs_n = 1'b1;
        ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; ba = '0; a = '0;

        do_reset();
        chk("rst_err", err, 0);
        chk("rst_count", err_count, 0);
        chk("rst_open", open_banks, 0);

        // legal open / read / close
        step(0, C_ACT, 0, 0); nops(2); step(0, C_RD, 0, 0);
        chk("r033_open", open_banks, 4'b0001);
        nops(3); step(0, C_PRE, 0, 0);
        chk("r033_err", err, 0);
        chk("r033_close", open_banks, 4'b0000);

        do_reset();
        step(0, C_ACT, 1, 0); step(0, C_RD, 1, 0);
        chk("r034_err", err, 1);
        chk("r034_code", err_code, 3);
        chk("r034_bank", err_bank, 1);
        chk("r034_count", err_count, 1);

        do_reset();
        step(0, C_ACT, 0, 0); step(0, C_ACT, 1, 0);
        chk("r035_code", err_code, 7);
        chk("r035_bank", err_bank, 1);
        chk("r035_open", open_banks, 4'b0011);

        do_reset();
        step(0, C_ACT, 2, 0); nops(9); step(0, C_REF, 0, 0);
        chk("r036_code", err_code, 9);
        step(0, C_NOP, 0, 0); step(0, C_ACT, 1, 0);
        chk("r036_code2", err_code, 9);
        chk("r036_count", err_count, 2);

        do_reset();
        nops(100);
        chk("r037_early", err, 0);
        nops(1);
        chk("r037_code", err_code, 11);
        chk("r037_count", err_count, 1);
        nops(20);
        chk("r037_hold", err_count, 1);

        do_reset();
        step(0, C_MRS, 0, 13'h0030);
        chk("r038_code", err_code, 10);
        step(1, C_NOP, 0, 0);
        chk("r038_err", err, 0);
        chk("r038_code0", err_code, 0);
        chk("r038_count", err_count, 0);

        // mode register write matching the expected value is legal
        do_reset();
        step(0, C_MRS, 0, MODE);
        chk("mrs_ok", err, 0);

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            roll = $urandom_range(0, 99);
            b    = $urandom_range(0, BANKS - 1);
            addr = $urandom_range(0, (1 << A_W) - 1);
            if      (roll < 30) c = C_NOP;
            else if (roll < 45) c = C_ACT;
            else if (roll < 55) c = C_RD;
            else if (roll < 62) c = C_WR;
            else if (roll < 78) c = C_PRE;
            else if (roll < 84) c = C_REF;
            else if (roll < 87) c = C_MRS;
            else if (roll < 93) c = C_DESEL;
            else                c = C_CKE;
            if (c == C_MRS && $urandom_range(0, 1) == 1) begin
                b = 0;
                addr = MODE;
            end
            step(($urandom_range(0, 149) == 0), c, b, addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_timing_checker.md
SDRAM_TIMING_CHECKER -- requirements
Module: sdram_timing_checker

Interface
REQ-001 SHALL have parameter BANKS, default 4, number of banks (power of two, 2..8).
REQ-002 SHALL have parameter A_W, default 13, address bus width.
REQ-003 SHALL have parameters T_RCD=2, T_RAS=5, T_RC=7, T_RP=2, T_RRD=2, T_RFC=7, all minimum command spacings in clk cycles (1..255).
REQ-004 SHALL have parameter REF_ROWS, default 8192, refresh commands per refresh window.
REQ-005 SHALL have parameter T_REFW, default 6400000, refresh window length in cycles.
REQ-006 SHALL have parameter MODE_EXPECT, default 15'h0020, the only legal MRS {ba,a} value.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  reset; synchronous and active-high.
REQ-009 cke_n, cs_n, ras_n, cas_n, we_n  in  1 each  SDRAM command pins.
REQ-010 ba  in  clog2(BANKS)  bank address.
REQ-011 a  in  A_W  address; a[10] selects all-bank precharge.
REQ-012 open_banks  out  BANKS  bit n high while bank n is active.
REQ-013 err  out  1  sticky violation flag.
REQ-014 err_code  out  4  code of the first violation.
REQ-015 err_bank  out  clog2(BANKS)  bank of the first violation (0 if not bank-specific).
REQ-016 err_count  out  16  violating cycles, saturating at 16'hFFFF.

Function
REQ-017 SHALL decode a command only when cke_n=0 and cs_n=0; otherwise treat the cycle as NOP.
REQ-018 SHALL decode {ras_n,cas_n,we_n}: 011 ACT, 101 RD, 100 WR, 010 PRE (all banks if a[10]=1), 001 REF, 000 MRS, 111/110 NOP.
REQ-019 SHALL keep per-bank state IDLE/ACTIVE: ACT moves the addressed bank IDLE->ACTIVE; PRE moves the addressed bank, or all banks, to IDLE; PRE to an IDLE bank is legal and causes no change.
REQ-020 SHALL keep per-bank saturating cycle counters since last ACT and since last PRE, plus global counters since last ACT (any bank) and since last REF.
REQ-021 Spacing rule: command at cycle n following reference event at cycle m is legal iff n-m >= T.
REQ-022 Error codes: 1 ACT to ACTIVE bank; 2 RD/WR to IDLE bank; 3 RD/WR before T_RCD; 4 PRE of ACTIVE bank before T_RAS; 5 ACT before T_RC of the same bank; 6 ACT before T_RP of the same bank, or REF before T_RP of any bank; 7 ACT before T_RRD of any bank; 8 any non-NOP command before T_RFC; 9 REF with any bank ACTIVE; 10 MRS with {ba,a} != MODE_EXPECT or any bank ACTIVE; 11 refresh window expired.
REQ-023 When several violations occur in one cycle, the lowest code SHALL be reported.
REQ-024 err, err_code and err_bank SHALL latch on the first violation and hold until rst; later violations only increment err_count.
REQ-025 A violating command SHALL still update bank state and counters as if legal.
REQ-026 err SHALL assert on the cycle after the violating command is sampled (1-cycle latency).
REQ-027 SHALL count REF commands modulo REF_ROWS; on a REF that finds the count at 0, SHALL restart the refresh-window cycle counter.
REQ-028 Refresh-window counter reaching T_REFW SHALL raise code 11 once, then saturate.
REQ-029 Counters SHALL saturate at their maximum and never wrap.

Reset
REQ-030 On rst: all banks IDLE, open_banks=0, err=0, err_code=0, err_bank=0, err_count=0, refresh count=0, refresh-window counter=0.
REQ-031 On rst: all spacing counters SHALL be set to saturated, so the first command after reset is legal.
REQ-032 rst asserted mid-burst of commands SHALL override any simultaneous command; that command is ignored.

Verification
REQ-033 ACT b0, 2 NOP, RD b0, 3 NOP, PRE b0 -> err=0, open_banks 0001->0000.
REQ-034 ACT b1, RD b1 next cycle -> err=1, err_code=3, err_bank=1, err_count=1.
REQ-035 ACT b0 at cycle 0, ACT b1 at cycle 1 -> err_code=7, err_bank=1; open_banks=0011.
REQ-036 ACT b2 then REF after 10 cycles -> err_code=9; same cycle as a T_RFC violation in a later cycle leaves err_code=9 and err_count=2.
REQ-037 T_REFW=100, REF_ROWS=2, no REF for 100 cycles -> err_code=11 at cycle 101, err_count=1, no further increments.
REQ-038 MRS with {ba,a}=15'h0030 -> err_code=10; rst next cycle -> all outputs 0.
